// File: rtl/led_pwm_bank.sv
// led_pwm_bank: parametrised LED/GPIO output bank.
//   NCH channels. Each channel is static or PWM and has its own output enable.
//   The bank has a shared prescaled period counter, double-buffered duty values
//   and a threshold comparator on compare_in that pulses irq on a rising crossing.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cfg_we/cfg_re     register write/read strobes; cfg_addr selects the register
//   cfg_wdata         write data (bits above the register width are ignored)
//   cfg_rdata         registered read data, zero-extended, held while cfg_re = 0
//   compare_in        value compared against the threshold register
//   led_out           registered channel outputs
//   io_oeb            registered pad output-enable, active low
//   irq               one-cycle pulse when compare_in rises to/above threshold
module led_pwm_bank #(
  parameter int NCH = 7,
  parameter int CW  = 8,
  parameter int PW  = 16,
  parameter int AW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic            cfg_re,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata,
  input  logic [CW-1:0]   compare_in,
  output logic [NCH-1:0]  led_out,
  output logic [NCH-1:0]  io_oeb,
  output logic            irq
);

  localparam logic [AW-1:0] ADDR_MODE  = AW'(NCH);
  localparam logic [AW-1:0] ADDR_LEVEL = AW'(NCH + 1);
  localparam logic [AW-1:0] ADDR_OE    = AW'(NCH + 2);
  localparam logic [AW-1:0] ADDR_PRE   = AW'(NCH + 3);
  localparam logic [AW-1:0] ADDR_THR   = AW'(NCH + 4);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  logic [CW-1:0]  duty_shadow_r [NCH];
  logic [CW-1:0]  duty_active_r [NCH];
  logic [NCH-1:0] mode_r;
  logic [NCH-1:0] level_r;
  logic [NCH-1:0] oe_r;
  logic [PW-1:0]  prescale_r;
  logic [PW-1:0]  pcnt_r;
  logic [CW-1:0]  threshold_r;
  logic [CW-1:0]  cnt_r;
  logic [NCH-1:0] led_r;
  logic [NCH-1:0] oeb_r;
  logic [15:0]    rdata_r;
  logic [CW-1:0]  compare_q_r;
  logic           hit_r;
  logic           hit_d_r;

  logic           tick_s;
  logic           boundary_s;
  logic [NCH-1:0] duty_wr_s;
  logic           wr_mode_s;
  logic           wr_level_s;
  logic           wr_oe_s;
  logic           wr_pre_s;
  logic           wr_thr_s;
  logic [NCH-1:0] led_next_s;
  logic [15:0]    rd_mux_s;
  logic           unused_wdata_s;

  // Upper write-data bits are intentionally ignored.
  assign unused_wdata_s = &{1'b0, cfg_wdata};

  // Write decode and prescaler / period-boundary strobes.
  always_comb begin
    tick_s     = (pcnt_r == prescale_r);
    boundary_s = tick_s && (cnt_r == CNT_MAX);
    wr_mode_s  = cfg_we && (cfg_addr == ADDR_MODE);
    wr_level_s = cfg_we && (cfg_addr == ADDR_LEVEL);
    wr_oe_s    = cfg_we && (cfg_addr == ADDR_OE);
    wr_pre_s   = cfg_we && (cfg_addr == ADDR_PRE);
    wr_thr_s   = cfg_we && (cfg_addr == ADDR_THR);
    duty_wr_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_wr_s[i] = cfg_we && (cfg_addr == AW'(i));
    end
  end

  // Read multiplexer; unmapped addresses read as zero.
  always_comb begin
    rd_mux_s = 16'h0000;
    case (cfg_addr)
      ADDR_MODE:  rd_mux_s = 16'(mode_r);
      ADDR_LEVEL: rd_mux_s = 16'(level_r);
      ADDR_OE:    rd_mux_s = 16'(oe_r);
      ADDR_PRE:   rd_mux_s = 16'(prescale_r);
      ADDR_THR:   rd_mux_s = 16'(threshold_r);
      default: begin
        for (int i = 0; i < NCH; i++) begin
          rd_mux_s = rd_mux_s | ((cfg_addr == AW'(i)) ? 16'(duty_shadow_r[i]) : 16'h0000);
        end
      end
    endcase
  end

  // Next channel outputs: PWM compare against the active duty, or static level.
  always_comb begin
    led_next_s = '0;
    for (int i = 0; i < NCH; i++) begin
      led_next_s[i] = mode_r[i] ? (cnt_r < duty_active_r[i]) : level_r[i];
    end
  end

  // Control registers and the registered output-enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r      <= '0;
      level_r     <= '0;
      oe_r        <= '0;
      prescale_r  <= '0;
      threshold_r <= '0;
      oeb_r       <= '1;
    end else begin
      if (wr_mode_s)  mode_r      <= cfg_wdata[NCH-1:0];
      if (wr_level_s) level_r     <= cfg_wdata[NCH-1:0];
      if (wr_oe_s)    oe_r        <= cfg_wdata[NCH-1:0];
      if (wr_pre_s)   prescale_r  <= cfg_wdata[PW-1:0];
      if (wr_thr_s)   threshold_r <= cfg_wdata[CW-1:0];
      // io_oeb follows a new oe value on the very edge it is written.
      oeb_r <= wr_oe_s ? ~cfg_wdata[NCH-1:0] : ~oe_r;
    end
  end

  // Duty shadow registers; active copies reload only on a period boundary,
  // with a same-cycle write passed straight through to the active copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        duty_shadow_r[i] <= '0;
        duty_active_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (duty_wr_s[i]) duty_shadow_r[i] <= cfg_wdata[CW-1:0];
        if (boundary_s) begin
          duty_active_r[i] <= duty_wr_s[i] ? cfg_wdata[CW-1:0] : duty_shadow_r[i];
        end
      end
    end
  end

  // Prescaler and period counter; a prescale write restarts the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (wr_pre_s || tick_s) pcnt_r <= '0;
      else                    pcnt_r <= pcnt_r + PW'(1);
      if (tick_s) cnt_r <= cnt_r + CW'(1);
    end
  end

  // Registered channel outputs and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r   <= '0;
      rdata_r <= 16'h0000;
    end else begin
      led_r <= led_next_s;
      if (cfg_re) rdata_r <= rd_mux_s;
    end
  end

  // Compare pipeline: input register, threshold compare, edge-detect delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      compare_q_r <= '0;
      hit_r       <= 1'b0;
      hit_d_r     <= 1'b0;
    end else begin
      compare_q_r <= compare_in;
      hit_r       <= (compare_q_r >= threshold_r);
      hit_d_r     <= hit_r;
    end
  end

  assign led_out   = led_r;
  assign io_oeb    = oeb_r;
  assign cfg_rdata = rdata_r;
  assign irq       = hit_r & ~hit_d_r;

endmodule
